// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT stream controller and its frame buffers.
package fft_pkg;

    localparam int unsigned FFT_N  = 8;
    localparam int unsigned FFT_DW = 16;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        UNLOAD
    } ctrl_state_t;

    // Bit offset of element idx inside a packed frame of dw-bit elements.
    function automatic int unsigned pack_lsb(input int unsigned idx, input int unsigned dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/fft_8_frame_buf.sv
// N-entry complex register file: indexed write, whole-frame parallel load,
// indexed read and a packed read of the full frame.
module fft_8_frame_buf
    import fft_pkg::*;
#(
    parameter int unsigned N  = FFT_N,
    parameter int unsigned DW = FFT_DW,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [IW-1:0]     wr_idx_i,
    input  logic [DW-1:0]     wr_real_i,
    input  logic [DW-1:0]     wr_imag_i,
    input  logic              ld_en_i,
    input  logic [N*DW-1:0]   ld_real_i,
    input  logic [N*DW-1:0]   ld_imag_i,
    input  logic [IW-1:0]     rd_idx_i,
    output logic [DW-1:0]     rd_real_o,
    output logic [DW-1:0]     rd_imag_o,
    output logic [N*DW-1:0]   pk_real_o,
    output logic [N*DW-1:0]   pk_imag_o
);

    logic [DW-1:0] re_q [N];
    logic [DW-1:0] im_q [N];
    logic [DW-1:0] re_d [N];
    logic [DW-1:0] im_d [N];

    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            re_d[k] = re_q[k];
            im_d[k] = im_q[k];
            if (ld_en_i) begin
                re_d[k] = ld_real_i[pack_lsb(k, DW) +: DW];
                im_d[k] = ld_imag_i[pack_lsb(k, DW) +: DW];
            end else if (wr_en_i && (wr_idx_i == IW'(k))) begin
                re_d[k] = wr_real_i;
                im_d[k] = wr_imag_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N); k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                re_q[k] <= re_d[k];
                im_q[k] <= im_d[k];
            end
        end
    end

    assign rd_real_o = re_q[rd_idx_i];
    assign rd_imag_o = im_q[rd_idx_i];

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign pk_real_o[pack_lsb(k, DW) +: DW] = re_q[k];
        assign pk_imag_o[pack_lsb(k, DW) +: DW] = im_q[k];
    end

endmodule

// File: rtl/fft_8_stream_ctrl.sv
// Stream sequencer around a parallel 8-point FFT core: collect a frame, launch
// the core under a watchdog, then replay the captured bins on the output stream.
module fft_8_stream_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N       = FFT_N,
    parameter int unsigned DW      = FFT_DW,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DW-1:0]     in_real_i,
    input  logic [DW-1:0]     in_imag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DW-1:0]     out_real_o,
    output logic [DW-1:0]     out_imag_o,
    output logic              out_last_o,
    output logic              core_start_o,
    output logic [N*DW-1:0]   core_in_real_o,
    output logic [N*DW-1:0]   core_in_imag_o,
    input  logic              core_done_i,
    input  logic [N*DW-1:0]   core_out_real_i,
    input  logic [N*DW-1:0]   core_out_imag_i,
    output logic              busy_o,
    output logic              err_timeout_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    ctrl_state_t   state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic in_hs, out_hs, in_last, rd_last, wdog_exp, capture;

    logic [DW-1:0] unused_ibuf_rd_real, unused_ibuf_rd_imag;
    logic [N*DW-1:0] unused_obuf_pk_real, unused_obuf_pk_imag;

    assign in_hs    = in_valid_i && in_ready_o;
    assign out_hs   = out_valid_o && out_ready_i;
    assign in_last  = (wr_idx_q == IW'(N - 1));
    assign rd_last  = (rd_idx_q == IW'(N - 1));
    assign wdog_exp = (wdog_q == WW'(TIMEOUT - 1));
    assign capture  = (state_q == WAIT) && core_done_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_hs && in_last) state_d = START;
            START:   state_d = WAIT;
            // A completion in the final watchdog cycle still counts.
            WAIT:    if (core_done_i) state_d = UNLOAD;
                     else if (wdog_exp) state_d = LOAD;
            UNLOAD:  if (out_hs && rd_last) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready_o   = 1'b0;
        core_start_o = 1'b0;
        out_valid_o  = 1'b0;
        busy_o       = 1'b1;
        case (state_q)
            LOAD: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
            end
            START:   core_start_o = 1'b1;
            UNLOAD:  out_valid_o  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        if (in_hs) begin
            wr_idx_d = in_last ? '0 : wr_idx_q + 1'b1;
        end
        if (state_q == START) begin
            wdog_d = '0;
        end else if (state_q == WAIT) begin
            wdog_d = wdog_q + 1'b1;
            if (!core_done_i && wdog_exp) begin
                err_d = 1'b1;
            end
        end
        if (capture) begin
            rd_idx_d = '0;
        end else if (out_hs) begin
            rd_idx_d = rd_last ? '0 : rd_idx_q + 1'b1;
            if (rd_last) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Input frame: written only in LOAD, so the core sees a stable frame START..WAIT.
    fft_8_frame_buf #(
        .N  (N),
        .DW (DW)
    ) u_ibuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (in_hs),
        .wr_idx_i  (wr_idx_q),
        .wr_real_i (in_real_i),
        .wr_imag_i (in_imag_i),
        .ld_en_i   (1'b0),
        .ld_real_i ('0),
        .ld_imag_i ('0),
        .rd_idx_i  ('0),
        .rd_real_o (unused_ibuf_rd_real),
        .rd_imag_o (unused_ibuf_rd_imag),
        .pk_real_o (core_in_real_o),
        .pk_imag_o (core_in_imag_o)
    );

    fft_8_frame_buf #(
        .N  (N),
        .DW (DW)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (1'b0),
        .wr_idx_i  ('0),
        .wr_real_i ('0),
        .wr_imag_i ('0),
        .ld_en_i   (capture),
        .ld_real_i (core_out_real_i),
        .ld_imag_i (core_out_imag_i),
        .rd_idx_i  (rd_idx_q),
        .rd_real_o (out_real_o),
        .rd_imag_o (out_imag_o),
        .pk_real_o (unused_obuf_pk_real),
        .pk_imag_o (unused_obuf_pk_imag)
    );

    assign out_last_o    = out_valid_o && rd_last;
    assign err_timeout_o = err_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule
